// File: rtl/key_search_pkg.sv
// Shared types for the ARC4 key-search sequencer: FSM state encoding and default key width.
package key_search_pkg;

    localparam int KEY_W_DEFAULT = 24;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef logic [KEY_W_DEFAULT-1:0] key_t;

endpackage

// File: rtl/key_search_ctrl_if.sv
// Handshake bundle between the key-search sequencer, its start logic and the check engine.
// KEY_SEARCH_STOP_EN adds the stop input used by dual-lane search.
interface key_search_ctrl_if
    import key_search_pkg::*;
#(
    parameter int KEY_W = KEY_W_DEFAULT
);
    logic             en;
    logic             rdy;
    logic             chk_rdy;
    logic             chk_en;
    logic [KEY_W-1:0] trial_key;
    logic             chk_done;
    logic             chk_pass;
    logic [KEY_W-1:0] key;
    logic             done;
    logic             key_valid;
`ifdef KEY_SEARCH_STOP_EN
    logic             stop;

    modport master (
        output en, chk_rdy, chk_done, chk_pass, stop,
        input  rdy, chk_en, trial_key, key, done, key_valid
    );

    modport slave (
        input  en, chk_rdy, chk_done, chk_pass, stop,
        output rdy, chk_en, trial_key, key, done, key_valid
    );
`else
    modport master (
        output en, chk_rdy, chk_done, chk_pass,
        input  rdy, chk_en, trial_key, key, done, key_valid
    );

    modport slave (
        input  en, chk_rdy, chk_done, chk_pass,
        output rdy, chk_en, trial_key, key, done, key_valid
    );
`endif

endinterface

// File: rtl/key_step_cnt.sv
// Candidate key stepper: loads KEY_START, advances by KEY_STEP and flags the last candidate,
// i.e. the one whose successor would not fit in KEY_W bits.
module key_step_cnt
    import key_search_pkg::*;
#(
    parameter int KEY_W     = KEY_W_DEFAULT,
    parameter int KEY_START = 0,
    parameter int KEY_STEP  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             adv_i,
    output logic [KEY_W-1:0] cnt_o,
    output logic             last_o
);

    localparam logic [KEY_W-1:0] START_K  = KEY_W'(KEY_START);
    localparam logic [KEY_W:0]   STEP_EXT = (KEY_W+1)'(KEY_STEP);

    logic [KEY_W-1:0] cnt_q;
    logic [KEY_W:0]   sum;

    // Carry out of the widened sum means the key space is used up; never wrap to 0.
    assign sum    = {1'b0, cnt_q} + STEP_EXT;
    assign last_o = sum[KEY_W];
    assign cnt_o  = cnt_q;

    always_ff @(posedge clk) begin
        if (rst || load_i) begin
            cnt_q <= START_K;
        end else if (adv_i) begin
            cnt_q <= sum[KEY_W-1:0];
        end
    end

endmodule

// File: rtl/key_search_ctrl.sv
// ARC4 brute-force key-search sequencer: walks candidate keys through the check engine and
// publishes {key, done, key_valid} for the display. KEY_SEARCH_STOP_EN enables early stop.
//
//  state | meaning
//  IDLE  | after reset, waiting for en
//  ISSUE | trial_key ready, strobing chk_en as soon as chk_rdy allows
//  WAIT  | candidate in flight, waiting for chk_done
//  DONE  | result held (found or exhausted), en restarts the search
module key_search_ctrl
    import key_search_pkg::*;
#(
    parameter int KEY_W     = KEY_W_DEFAULT,
    parameter int KEY_START = 0,
    parameter int KEY_STEP  = 1
) (
    input  logic               clk,
    input  logic               rst,
    key_search_ctrl_if.slave   bus
);

    state_e           state_q;
    logic             rdy_q;
    logic             done_q;
    logic             key_valid_q;
    logic [KEY_W-1:0] key_q;

    logic [KEY_W-1:0] trial_key;
    logic             cnt_last;
    logic             cnt_load;
    logic             cnt_adv;
    logic             stop_req;
    logic             start_acc;
    logic             issue_fire;
    logic             result_miss;

`ifdef KEY_SEARCH_STOP_EN
    assign stop_req = bus.stop;
`else
    assign stop_req = 1'b0;
`endif

    // rdy_q is high exactly in IDLE and DONE, so it doubles as the start-accept qualifier.
    assign start_acc   = rdy_q && bus.en;
    assign issue_fire  = (state_q == ISSUE) && bus.chk_rdy && !stop_req;
    assign result_miss = (state_q == WAIT) && bus.chk_done && !bus.chk_pass;

    assign cnt_load = start_acc;
    assign cnt_adv  = result_miss && !cnt_last && !stop_req;

    key_step_cnt #(
        .KEY_W     (KEY_W),
        .KEY_START (KEY_START),
        .KEY_STEP  (KEY_STEP)
    ) u_step_cnt (
        .clk    (clk),
        .rst    (rst),
        .load_i (cnt_load),
        .adv_i  (cnt_adv),
        .cnt_o  (trial_key),
        .last_o (cnt_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rdy_q       <= 1'b1;
            done_q      <= 1'b0;
            key_valid_q <= 1'b0;
            key_q       <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (bus.en) begin
                        state_q     <= ISSUE;
                        rdy_q       <= 1'b0;
                        done_q      <= 1'b0;
                        key_valid_q <= 1'b0;
                    end
                end
                ISSUE: begin
                    if (stop_req) begin
                        state_q     <= DONE;
                        rdy_q       <= 1'b1;
                        done_q      <= 1'b1;
                        key_valid_q <= 1'b0;
                    end else if (bus.chk_rdy) begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    // A passing result in the same cycle as stop still reports its key.
                    if (bus.chk_done && bus.chk_pass) begin
                        state_q     <= DONE;
                        rdy_q       <= 1'b1;
                        done_q      <= 1'b1;
                        key_valid_q <= 1'b1;
                        key_q       <= trial_key;
                    end else if (stop_req || (bus.chk_done && cnt_last)) begin
                        state_q     <= DONE;
                        rdy_q       <= 1'b1;
                        done_q      <= 1'b1;
                        key_valid_q <= 1'b0;
                    end else if (bus.chk_done) begin
                        state_q <= ISSUE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    rdy_q   <= 1'b1;
                end
            endcase
        end
    end

    assign bus.rdy       = rdy_q;
    assign bus.chk_en    = issue_fire;
    assign bus.trial_key = trial_key;
    assign bus.key       = key_q;
    assign bus.done      = done_q;
    assign bus.key_valid = key_valid_q;

endmodule

// File: tb/tb_key_search_ctrl.sv
// Bench for key_search_ctrl: three lanes (24-bit default, 4-bit step 1, 4-bit start 1 step 2)
// driven by a randomized check-engine model and compared against an arithmetic key-walk model.
module tb_key_search_ctrl;
    import key_search_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    key_search_ctrl_if #(.KEY_W(KEY_W_DEFAULT)) b0 ();
    key_search_ctrl_if #(.KEY_W(4))             b1 ();
    key_search_ctrl_if #(.KEY_W(4))             b2 ();

    key_search_ctrl #(.KEY_W(KEY_W_DEFAULT), .KEY_START(0), .KEY_STEP(1))
        u_dut0 (.clk(clk), .rst(rst), .bus(b0.slave));
    key_search_ctrl #(.KEY_W(4), .KEY_START(0), .KEY_STEP(1))
        u_dut1 (.clk(clk), .rst(rst), .bus(b1.slave));
    key_search_ctrl #(.KEY_W(4), .KEY_START(1), .KEY_STEP(2))
        u_dut2 (.clk(clk), .rst(rst), .bus(b2.slave));

    typedef struct packed {
        logic        rdy;
        logic        chk_en;
        logic        done;
        logic        key_valid;
        logic [23:0] key;
        logic [23:0] trial;
    } obs_t;

    int checks   = 0;
    int failures = 0;

    bit pass_en_a [3];
    int pass_key_a[3];
    bit gate_a    [3];
    int lat_lo    [3];
    int lat_hi    [3];
    bit pend      [3];
    int lat       [3];
    int cur       [3];
    int tq0[$];
    int tq1[$];
    int tq2[$];
    int exp_q[$];

    function automatic int lane_w(input int ln);
        return (ln == 0) ? 24 : 4;
    endfunction

    function automatic int lane_start(input int ln);
        return (ln == 2) ? 1 : 0;
    endfunction

    function automatic int lane_step(input int ln);
        return (ln == 2) ? 2 : 1;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Check-engine models: random chk_rdy back-pressure, random result latency, garbage chk_pass
    // when no result is being returned.
    always @(negedge clk) begin
        b0.chk_done = 1'b0;
        b0.chk_pass = 1'($urandom_range(0, 1));
        b0.chk_rdy  = !gate_a[0] && ($urandom_range(0, 3) != 0);
        if (pend[0]) begin
            if (lat[0] == 0) begin
                check("l0_trial_stable", 64'(b0.trial_key), 64'(cur[0]));
                b0.chk_done = 1'b1;
                b0.chk_pass = pass_en_a[0] && (cur[0] == pass_key_a[0]);
                pend[0] = 1'b0;
            end else begin
                lat[0] = lat[0] - 1;
            end
        end
        #1;
        if (b0.chk_en === 1'b1) begin
            tq0.push_back(int'(b0.trial_key));
            cur[0]  = int'(b0.trial_key);
            pend[0] = 1'b1;
            lat[0]  = $urandom_range(lat_lo[0], lat_hi[0]);
        end
    end

    always @(negedge clk) begin
        b1.chk_done = 1'b0;
        b1.chk_pass = 1'($urandom_range(0, 1));
        b1.chk_rdy  = !gate_a[1] && ($urandom_range(0, 3) != 0);
        if (pend[1]) begin
            if (lat[1] == 0) begin
                check("l1_trial_stable", 64'(b1.trial_key), 64'(cur[1]));
                b1.chk_done = 1'b1;
                b1.chk_pass = pass_en_a[1] && (cur[1] == pass_key_a[1]);
                pend[1] = 1'b0;
            end else begin
                lat[1] = lat[1] - 1;
            end
        end
        #1;
        if (b1.chk_en === 1'b1) begin
            tq1.push_back(int'(b1.trial_key));
            cur[1]  = int'(b1.trial_key);
            pend[1] = 1'b1;
            lat[1]  = $urandom_range(lat_lo[1], lat_hi[1]);
        end
    end

    always @(negedge clk) begin
        b2.chk_done = 1'b0;
        b2.chk_pass = 1'($urandom_range(0, 1));
        b2.chk_rdy  = !gate_a[2] && ($urandom_range(0, 3) != 0);
        if (pend[2]) begin
            if (lat[2] == 0) begin
                check("l2_trial_stable", 64'(b2.trial_key), 64'(cur[2]));
                b2.chk_done = 1'b1;
                b2.chk_pass = pass_en_a[2] && (cur[2] == pass_key_a[2]);
                pend[2] = 1'b0;
            end else begin
                lat[2] = lat[2] - 1;
            end
        end
        #1;
        if (b2.chk_en === 1'b1) begin
            tq2.push_back(int'(b2.trial_key));
            cur[2]  = int'(b2.trial_key);
            pend[2] = 1'b1;
            lat[2]  = $urandom_range(lat_lo[2], lat_hi[2]);
        end
    end

    function automatic obs_t observe(input int ln);
        obs_t o;
        o = '0;
        case (ln)
            0: begin
                o.rdy = b0.rdy; o.chk_en = b0.chk_en; o.done = b0.done;
                o.key_valid = b0.key_valid; o.key = b0.key; o.trial = b0.trial_key;
            end
            1: begin
                o.rdy = b1.rdy; o.chk_en = b1.chk_en; o.done = b1.done;
                o.key_valid = b1.key_valid; o.key = {20'd0, b1.key}; o.trial = {20'd0, b1.trial_key};
            end
            default: begin
                o.rdy = b2.rdy; o.chk_en = b2.chk_en; o.done = b2.done;
                o.key_valid = b2.key_valid; o.key = {20'd0, b2.key}; o.trial = {20'd0, b2.trial_key};
            end
        endcase
        return o;
    endfunction

    function automatic int ntrials(input int ln);
        case (ln)
            0:       return tq0.size();
            1:       return tq1.size();
            default: return tq2.size();
        endcase
    endfunction

    function automatic int get_trial(input int ln, input int i);
        case (ln)
            0:       return tq0[i];
            1:       return tq1[i];
            default: return tq2[i];
        endcase
    endfunction

    task automatic clear_trials(input int ln);
        case (ln)
            0:       tq0.delete();
            1:       tq1.delete();
            default: tq2.delete();
        endcase
    endtask

    task automatic set_en(input int ln, input logic v);
        case (ln)
            0:       b0.en = v;
            1:       b1.en = v;
            default: b2.en = v;
        endcase
    endtask

    // Expected candidate walk: START, START+STEP, ... until the pass key or the last key
    // whose successor no longer fits in the lane's width. Returns 1 when the key is found.
    function automatic bit build_expected(input int ln, input bit pen, input int pkey);
        longint k   = lane_start(ln);
        longint top = (longint'(1) << lane_w(ln)) - 1;
        exp_q.delete();
        for (int guard = 0; guard < 4096; guard++) begin
            exp_q.push_back(int'(k));
            if (pen && k == pkey) return 1'b1;
            if (k + lane_step(ln) > top) return 1'b0;
            k = k + lane_step(ln);
        end
        return 1'b0;
    endfunction

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic pulse_en(input int ln);
        set_en(ln, 1'b1);
        tick();
        set_en(ln, 1'b0);
    endtask

    task automatic wait_trials(input int ln, input int n, input string tag);
        int k = 0;
        while (ntrials(ln) < n && k < 200) begin
            tick();
            k++;
        end
        check($sformatf("%s_in_time", tag), 64'(k < 200), 64'd1);
    endtask

    task automatic wait_quiet(input int ln, input string tag);
        int k = 0;
        while (pend[ln] && k < 50) begin
            tick();
            k++;
        end
        check($sformatf("%s_quiet", tag), 64'(k < 50), 64'd1);
    endtask

    task automatic run_search(input int ln, input bit pen, input int pkey,
                              input int gate_cycles, input bit busy_en, input string tag);
        obs_t o;
        bit   found;
        bit   pulsed;
        int   n;
        int   nt;
        wait_quiet(ln, tag);
        pass_en_a[ln]  = pen;
        pass_key_a[ln] = pkey;
        found = build_expected(ln, pen, pkey);
        clear_trials(ln);
        if (gate_cycles > 0) gate_a[ln] = 1'b1;
        tick();
        pulse_en(ln);
        o = observe(ln);
        check($sformatf("%s_start_done", tag), 64'(o.done), 64'd0);
        check($sformatf("%s_start_kv", tag), 64'(o.key_valid), 64'd0);
        check($sformatf("%s_start_rdy", tag), 64'(o.rdy), 64'd0);
        check($sformatf("%s_start_trial", tag), 64'(o.trial), 64'(lane_start(ln)));
        if (gate_cycles > 0) begin
            for (int c = 0; c < gate_cycles; c++) begin
                o = observe(ln);
                check($sformatf("%s_gated_chk_en%0d", tag, c), 64'(o.chk_en), 64'd0);
                tick();
            end
            check($sformatf("%s_gated_ntrials", tag), 64'(ntrials(ln)), 64'd0);
            gate_a[ln] = 1'b0;
        end
        n = 0;
        pulsed = 1'b0;
        o = observe(ln);
        while (o.done !== 1'b1 && n < 2000) begin
            if (busy_en && !pulsed && ntrials(ln) >= 2) begin
                check($sformatf("%s_busy_rdy", tag), 64'(o.rdy), 64'd0);
                set_en(ln, 1'b1);
                pulsed = 1'b1;
                tick();
                set_en(ln, 1'b0);
            end else begin
                tick();
            end
            n++;
            o = observe(ln);
        end
        check($sformatf("%s_done_in_time", tag), 64'(n < 2000), 64'd1);
        check($sformatf("%s_done", tag), 64'(o.done), 64'd1);
        check($sformatf("%s_rdy", tag), 64'(o.rdy), 64'd1);
        check($sformatf("%s_key_valid", tag), 64'(o.key_valid), 64'(found));
        if (found) check($sformatf("%s_key", tag), 64'(o.key), 64'(pkey));
        repeat (6) tick();
        nt = ntrials(ln);
        check($sformatf("%s_ntrials", tag), 64'(nt), 64'(exp_q.size()));
        for (int i = 0; i < nt && i < exp_q.size(); i++)
            check($sformatf("%s_trial%0d", tag, i), 64'(get_trial(ln, i)), 64'(exp_q[i]));
        o = observe(ln);
        check($sformatf("%s_done_held", tag), 64'(o.done), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t o;
        rst   = 1'b1;
        b0.en = 1'b0;
        b1.en = 1'b0;
        b2.en = 1'b0;
`ifdef KEY_SEARCH_STOP_EN
        b0.stop = 1'b0;
        b1.stop = 1'b0;
        b2.stop = 1'b0;
`endif
        for (int i = 0; i < 3; i++) begin
            pass_en_a[i] = 1'b0; pass_key_a[i] = 0; gate_a[i] = 1'b0;
            lat_lo[i] = 0; lat_hi[i] = 3;
        end
        repeat (3) tick();
        rst = 1'b0;
        for (int ln = 0; ln < 3; ln++) begin
            o = observe(ln);
            check($sformatf("rst_l%0d_rdy", ln), 64'(o.rdy), 64'd1);
            check($sformatf("rst_l%0d_chk_en", ln), 64'(o.chk_en), 64'd0);
            check($sformatf("rst_l%0d_done", ln), 64'(o.done), 64'd0);
            check($sformatf("rst_l%0d_kv", ln), 64'(o.key_valid), 64'd0);
            check($sformatf("rst_l%0d_key", ln), 64'(o.key), 64'd0);
            check($sformatf("rst_l%0d_trial", ln), 64'(o.trial), 64'(lane_start(ln)));
        end

        // Reset held two cycles while lane 0 waits on a slow result; the late result is ignored.
        lat_lo[0] = 8; lat_hi[0] = 8;
        pass_en_a[0] = 1'b0;
        clear_trials(0);
        tick();
        pulse_en(0);
        wait_trials(0, 1, "t1_first_issue");
        tick();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        o = observe(0);
        check("t1_rdy", 64'(o.rdy), 64'd1);
        check("t1_done", 64'(o.done), 64'd0);
        check("t1_kv", 64'(o.key_valid), 64'd0);
        check("t1_chk_en", 64'(o.chk_en), 64'd0);
        check("t1_trial", 64'(o.trial), 64'd0);
        repeat (12) tick();
        o = observe(0);
        check("t1_late_done", 64'(o.done), 64'd0);
        check("t1_late_rdy", 64'(o.rdy), 64'd1);
        check("t1_late_ntrials", 64'(ntrials(0)), 64'd1);

        lat_lo[0] = 0; lat_hi[0] = 3;
        run_search(0, 1'b1, 3, 0, 1'b1, "t2_pass3");
        run_search(0, 1'b1, 2, 5, 1'b1, "t5_gated");
        run_search(0, 1'b1, 5, 0, 1'b0, "t6_restart");
        run_search(1, 1'b0, 0, 0, 1'b0, "t3_exhaust");
        run_search(2, 1'b1, 7, 0, 1'b1, "t4_step2");
        run_search(2, 1'b0, 0, 2, 1'b0, "t4_exhaust");

`ifdef KEY_SEARCH_STOP_EN
        lat_lo[0] = 6; lat_hi[0] = 6;
        pass_en_a[0] = 1'b0;
        wait_quiet(0, "stop_wait");
        clear_trials(0);
        tick();
        pulse_en(0);
        wait_trials(0, 1, "stop_wait_issue");
        tick();
        b0.stop = 1'b1;
        tick();
        b0.stop = 1'b0;
        o = observe(0);
        check("stop_wait_done", 64'(o.done), 64'd1);
        check("stop_wait_kv", 64'(o.key_valid), 64'd0);
        check("stop_wait_rdy", 64'(o.rdy), 64'd1);
        repeat (10) tick();
        check("stop_wait_ntrials", 64'(ntrials(0)), 64'd1);

        gate_a[0] = 1'b1;
        clear_trials(0);
        tick();
        pulse_en(0);
        b0.stop = 1'b1;
        tick();
        b0.stop = 1'b0;
        o = observe(0);
        check("stop_issue_done", 64'(o.done), 64'd1);
        check("stop_issue_kv", 64'(o.key_valid), 64'd0);
        gate_a[0] = 1'b0;
        repeat (4) tick();
        check("stop_issue_ntrials", 64'(ntrials(0)), 64'd0);
        lat_lo[0] = 0; lat_hi[0] = 3;
`endif

        for (int it = 0; it < 8; it++) begin
            int  ln;
            bit  pen;
            int  pkey;
            ln = $urandom_range(0, 2);
            lat_lo[ln] = 0;
            lat_hi[ln] = $urandom_range(0, 3);
            if (ln == 0) begin
                pen  = 1'b1;
                pkey = $urandom_range(0, 40);
            end else begin
                pen  = ($urandom_range(0, 3) != 0);
                pkey = $urandom_range(0, 15);
            end
            run_search(ln, pen, pkey, ($urandom_range(0, 1) != 0) ? 3 : 0,
                       ($urandom_range(0, 1) != 0), $sformatf("rnd%0d_l%0d", it, ln));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
